// File: rtl/pal_dma.sv
// Palette DMA: copies len 32-bit words from a byte-addressed source into palette RAM,
// one outstanding read at a time, writing only while vblank is high.
module pal_dma #(
    parameter int PAL_ADDR_W = 10,
    parameter int PAL_DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [31:0]           src_addr,
    input  logic [PAL_ADDR_W-1:0] dst_addr,
    input  logic [PAL_ADDR_W:0]   len,
    input  logic                  abort,
    input  logic                  vblank,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_req,
    output logic [31:0]           rd_addr,
    input  logic                  rd_ack,
    input  logic [PAL_DATA_W-1:0] rd_data,
    output logic                  pal_we,
    output logic [PAL_ADDR_W-1:0] pal_addr,
    output logic [PAL_DATA_W-1:0] pal_wdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WRITE,
        S_DRAIN,
        S_DONE
    } state_e;

    localparam logic [PAL_ADDR_W-1:0] DST_ONE = 1;
    localparam logic [PAL_ADDR_W:0]   REM_ONE = 1;
    localparam logic [PAL_ADDR_W:0]   REM_ZERO = '0;

    state_e                  state_q, state_d;
    logic [31:0]             src_q, src_d;
    logic [PAL_ADDR_W-1:0]   dst_q, dst_d;
    logic [PAL_ADDR_W:0]     rem_q, rem_d;
    logic [PAL_DATA_W-1:0]   word_q, word_d;

    // NOTE: registers take non-blocking assignments only; the reset branch clears every flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            word_q  <= word_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        rem_d     = rem_q;
        word_d    = word_q;
        busy      = 1'b0;
        done      = 1'b0;
        rd_req    = 1'b0;
        rd_addr   = '0;
        pal_we    = 1'b0;
        pal_addr  = '0;
        pal_wdata = '0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_d   = src_addr;
                    dst_d   = dst_addr;
                    rem_d   = len;
                    state_d = (len == REM_ZERO) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                busy    = 1'b1;
                rd_req  = 1'b1;
                rd_addr = src_q;
                // An ack landing with the abort closes the handshake, so there is nothing to drain.
                if (abort) begin
                    state_d = rd_ack ? S_IDLE : S_DRAIN;
                end else if (rd_ack) begin
                    word_d  = rd_data;
                    state_d = S_WRITE;
                end
            end
            S_DRAIN: begin
                busy    = 1'b1;
                rd_req  = 1'b1;
                rd_addr = src_q;
                if (rd_ack) begin
                    state_d = S_IDLE;
                end
            end
            S_WRITE: begin
                busy      = 1'b1;
                pal_addr  = dst_q;
                pal_wdata = word_q;
                if (abort) begin
                    state_d = S_IDLE;
                end else if (vblank) begin
                    pal_we  = 1'b1;
                    dst_d   = dst_q + DST_ONE;
                    src_d   = src_q + 32'd4;
                    rem_d   = rem_q - REM_ONE;
                    state_d = (rem_q == REM_ONE) ? S_DONE : S_REQ;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pal_dma.sv
// Bench for pal_dma: directed scenarios plus randomized traffic, all checked against a
// transfer-level reference model evaluated on every falling clock edge.
`timescale 1ns/1ps
module tb_pal_dma;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [31:0]   src_addr = '0;
    logic [AW-1:0] dst_addr = '0;
    logic [AW:0]   len = '0;
    logic          abort = 1'b0;
    logic          vblank = 1'b0;
    logic          rd_ack = 1'b0;
    logic [DW-1:0] rd_data = '0;
    logic          busy, done, rd_req, pal_we;
    logic [31:0]   rd_addr;
    logic [AW-1:0] pal_addr;
    logic [DW-1:0] pal_wdata;

    pal_dma #(.PAL_ADDR_W(AW), .PAL_DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .src_addr(src_addr),
        .dst_addr(dst_addr), .len(len), .abort(abort), .vblank(vblank),
        .busy(busy), .done(done), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_ack(rd_ack), .rd_data(rd_data), .pal_we(pal_we),
        .pal_addr(pal_addr), .pal_wdata(pal_wdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input bit ok, input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Source-side responder: acks each request after ack_delay cycles (negative = random 0..3).
    int ack_delay_fix = 0;
    bit spurious_en = 1'b0;
    int cur_delay = 0;
    int wait_cnt = 0;
    bit in_req = 1'b0;

    always @(posedge clk) begin
        #1;
        rd_data = $urandom;
        if (rd_req) begin
            if (!in_req) begin
                in_req    = 1'b1;
                wait_cnt  = 0;
                cur_delay = (ack_delay_fix < 0) ? int'($urandom_range(0, 3)) : ack_delay_fix;
            end
            if (wait_cnt >= cur_delay) begin
                rd_ack = 1'b1;
                in_req = 1'b0;
            end else begin
                rd_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            in_req = 1'b0;
            rd_ack = spurious_en && ($urandom_range(0, 3) == 0);
        end
    end

    // Reference model: one transfer described by what is left to copy.
    bit            m_valid = 1'b0;
    bit            m_zero = 1'b0;
    bit            m_active = 1'b0;
    bit            m_drain = 1'b0;
    bit            m_have = 1'b0;
    bit            m_done = 1'b0;
    logic [31:0]   m_src = '0;
    logic [AW-1:0] m_dst = '0;
    logic [DW-1:0] m_word = '0;
    int            m_left = 0;

    logic [31:0]   rd_log[$];
    logic [DW-1:0] ack_log[$];
    logic [AW-1:0] wr_addr_log[$];
    logic [DW-1:0] wr_data_log[$];
    int            done_count = 0;

    always @(negedge clk) begin
        bit exp_req;
        bit exp_we;
        if (m_valid) begin
            exp_req = m_active && !m_have;
            exp_we  = m_active && m_have && vblank && !abort;
            if (m_zero)
                check({busy, done, rd_req, pal_we} == 4'b0 && rd_addr == '0 && pal_addr == '0
                      && pal_wdata == '0, "reset_outputs_zero",
                      64'({busy, done, rd_req, pal_we}), 64'(0));
            check(busy == m_active, "busy", 64'(busy), 64'(m_active));
            check(done == m_done, "done", 64'(done), 64'(m_done));
            check(rd_req == exp_req, "rd_req", 64'(rd_req), 64'(exp_req));
            check(pal_we == exp_we, "pal_we", 64'(pal_we), 64'(exp_we));
            if (exp_req && rd_req)
                check(rd_addr == m_src, "rd_addr", 64'(rd_addr), 64'(m_src));
            if (exp_we && pal_we) begin
                check(pal_addr == m_dst, "pal_addr", 64'(pal_addr), 64'(m_dst));
                check(pal_wdata == m_word, "pal_wdata", 64'(pal_wdata), 64'(m_word));
            end
        end

        if (rst_n && rd_req && rd_ack) begin
            rd_log.push_back(rd_addr);
            ack_log.push_back(rd_data);
        end
        if (pal_we) begin
            wr_addr_log.push_back(pal_addr);
            wr_data_log.push_back(pal_wdata);
        end
        if (done) done_count++;

        m_zero = 1'b0;
        if (!rst_n) begin
            m_valid  = 1'b1;
            m_zero   = 1'b1;
            m_active = 1'b0;
            m_drain  = 1'b0;
            m_have   = 1'b0;
            m_done   = 1'b0;
        end else if (m_valid) begin
            if (m_done) begin
                m_done = 1'b0;
            end else if (!m_active) begin
                if (start) begin
                    m_src  = src_addr;
                    m_dst  = dst_addr;
                    m_left = int'(len);
                    if (m_left == 0) begin
                        m_done = 1'b1;
                    end else begin
                        m_active = 1'b1;
                        m_have   = 1'b0;
                        m_drain  = 1'b0;
                    end
                end
            end else if (m_drain) begin
                if (rd_ack) m_active = 1'b0;
            end else if (!m_have) begin
                if (abort) begin
                    if (rd_ack) m_active = 1'b0;
                    else m_drain = 1'b1;
                end else if (rd_ack) begin
                    m_word = rd_data;
                    m_have = 1'b1;
                end
            end else if (abort) begin
                m_active = 1'b0;
            end else if (vblank) begin
                m_dst  = m_dst + 10'd1;
                m_src  = m_src + 32'd4;
                m_left = m_left - 1;
                m_have = 1'b0;
                if (m_left == 0) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end
            end
        end
    end

    task automatic start_pulse(input logic [31:0] s, input logic [AW-1:0] d, input int n);
        @(posedge clk);
        #1;
        start    = 1'b1;
        src_addr = s;
        dst_addr = d;
        len      = (AW+1)'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles, input string name);
        bit ok = 1'b0;
        int i;
        for (i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (!busy && !done) begin
                ok = 1'b1;
                break;
            end
        end
        check(ok, name, 64'(i), 64'(max_cycles));
    endtask

    task automatic check_xfer(input logic [31:0] s, input logic [AW-1:0] d, input int n,
                              input int br, input int bw, input int ba, input string tag);
        logic [31:0]   ea;
        logic [AW-1:0] ed;
        check(rd_log.size() == br + n, {tag, "_reads"}, 64'(rd_log.size() - br), 64'(n));
        check(wr_addr_log.size() == bw + n, {tag, "_writes"}, 64'(wr_addr_log.size() - bw), 64'(n));
        if (rd_log.size() == br + n && wr_addr_log.size() == bw + n && ack_log.size() >= ba + n) begin
            for (int i = 0; i < n; i++) begin
                ea = s + 32'(4 * i);
                ed = d + AW'(i);
                check(rd_log[br+i] == ea, {tag, "_rd_addr"}, 64'(rd_log[br+i]), 64'(ea));
                check(wr_addr_log[bw+i] == ed, {tag, "_wr_addr"}, 64'(wr_addr_log[bw+i]), 64'(ed));
                check(wr_data_log[bw+i] == ack_log[ba+i], {tag, "_wr_data"},
                      64'(wr_data_log[bw+i]), 64'(ack_log[ba+i]));
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int br, bw, ba, bd, n;
        bit found;

        repeat (3) @(posedge clk);
        #1;
        check({busy, done, rd_req, pal_we} == 4'b0, "reset_state", 64'({busy, done, rd_req, pal_we}), 64'(0));
        rst_n = 1'b1;

        // Basic three-word copy, ack one cycle after each request.
        vblank = 1'b1;
        ack_delay_fix = 1;
        br = rd_log.size(); bw = wr_addr_log.size(); ba = ack_log.size(); bd = done_count;
        start_pulse(32'h1000, 10'h010, 3);
        wait_idle(100, "t1_timeout");
        check_xfer(32'h1000, 10'h010, 3, br, bw, ba, "t1");
        if (rd_log.size() == br + 3)
            check(rd_log[br+2] == 32'h1008, "t1_third_rd_addr", 64'(rd_log[br+2]), 64'h1008);
        check(done_count == bd + 1, "t1_done_once", 64'(done_count - bd), 64'(1));

        // Two cycles per word with same-cycle ack: done arrives 6 cycles into a 3-word copy.
        ack_delay_fix = 0;
        start_pulse(32'h5000, 10'h020, 3);
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done) break;
            n++;
        end
        check(n == 6, "t2_min_cost_cycles", 64'(n), 64'(6));
        wait_idle(20, "t2_timeout");

        // Address wrap on both sides.
        br = rd_log.size(); bw = wr_addr_log.size(); ba = ack_log.size();
        start_pulse(32'hFFFF_FFFC, 10'h3FF, 2);
        wait_idle(100, "t3_timeout");
        check_xfer(32'hFFFF_FFFC, 10'h3FF, 2, br, bw, ba, "t3");
        if (rd_log.size() == br + 2 && wr_addr_log.size() == bw + 2) begin
            check(rd_log[br+1] == 32'h0, "t3_rd_wrap", 64'(rd_log[br+1]), 64'h0);
            check(wr_addr_log[bw+1] == 10'h000, "t3_dst_wrap", 64'(wr_addr_log[bw+1]), 64'h0);
        end

        // vblank held low for 5 cycles in WRITE, then released.
        vblank = 1'b0;
        ba = ack_log.size();
        start_pulse(32'h2000, 10'h155, 1);
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check(!pal_we && !rd_req && busy, "t4_stall", 64'({pal_we, rd_req, busy}), 64'b001);
        end
        @(posedge clk);
        #1;
        vblank = 1'b1;
        @(negedge clk);
        check(pal_we && pal_addr == 10'h155, "t4_release_write", 64'({pal_we, pal_addr}), 64'({1'b1, 10'h155}));
        if (ack_log.size() == ba + 1)
            check(pal_wdata == ack_log[ba], "t4_release_data", 64'(pal_wdata), 64'(ack_log[ba]));
        wait_idle(20, "t4_timeout");

        // Abort during REQ: request held until the delayed ack, then idle with nothing written.
        ack_delay_fix = 3;
        bw = wr_addr_log.size(); ba = ack_log.size(); bd = done_count;
        start_pulse(32'h7000, 10'h0A0, 4);
        abort = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
            @(posedge clk);
            #1;
            abort = 1'b0;
        end
        abort = 1'b0;
        check(n == 4, "t5_busy_until_ack", 64'(n), 64'(4));
        repeat (3) @(negedge clk);
        check(wr_addr_log.size() == bw, "t5_no_write", 64'(wr_addr_log.size() - bw), 64'(0));
        check(done_count == bd, "t5_no_done", 64'(done_count - bd), 64'(0));
        check(ack_log.size() == ba + 1, "t5_drain_ack", 64'(ack_log.size() - ba), 64'(1));

        // Abort in WRITE with vblank high: no write that cycle.
        ack_delay_fix = 0;
        vblank = 1'b0;
        bw = wr_addr_log.size(); bd = done_count;
        start_pulse(32'h6000, 10'h077, 2);
        @(posedge clk);
        #1;
        abort  = 1'b1;
        vblank = 1'b1;
        @(negedge clk);
        check(!pal_we, "t6_abort_blocks_write", 64'(pal_we), 64'(0));
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        check(!busy && !done, "t6_abort_idle", 64'({busy, done}), 64'(0));
        repeat (3) @(negedge clk);
        check(wr_addr_log.size() == bw && done_count == bd, "t6_nothing_after",
              64'(wr_addr_log.size() - bw), 64'(0));

        // len = 0 completes at once; a start while busy is ignored.
        br = rd_log.size();
        start_pulse(32'hA000, 10'h000, 0);
        @(negedge clk);
        check(done && !rd_req && !busy, "t7_len0_done", 64'({done, rd_req, busy}), 64'b100);
        @(negedge clk);
        check(!done && !busy && rd_log.size() == br, "t7_len0_after", 64'({done, busy}), 64'(0));
        ack_delay_fix = 2;
        br = rd_log.size(); bw = wr_addr_log.size(); ba = ack_log.size(); bd = done_count;
        start_pulse(32'h3000, 10'h040, 4);
        repeat (3) @(posedge clk);
        start_pulse(32'h9000, 10'h200, 1);
        wait_idle(100, "t7_timeout");
        check_xfer(32'h3000, 10'h040, 4, br, bw, ba, "t7");
        check(done_count == bd + 1, "t7_done_once", 64'(done_count - bd), 64'(1));

        // Reset during WRITE of word 2 of 4.
        ack_delay_fix = 0;
        vblank = 1'b1;
        start_pulse(32'h4000, 10'h100, 4);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pal_we) begin
                found = 1'b1;
                break;
            end
        end
        check(found, "t8_first_write", 64'(found), 64'(1));
        @(posedge clk);
        #1;
        vblank = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check(busy && !rd_req && !pal_we, "t8_in_write", 64'({busy, rd_req, pal_we}), 64'b100);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        vblank = 1'b1;
        check({busy, done, rd_req, pal_we} == 4'b0 && rd_addr == '0 && pal_addr == '0 && pal_wdata == '0,
              "t8_reset_zero", 64'({busy, done, rd_req, pal_we}), 64'(0));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check(!rd_req && !pal_we, "t8_quiet_after_reset", 64'({rd_req, pal_we}), 64'(0));
        end

        // Randomized traffic: random starts, aborts, vblank, ack delays and stray acks.
        ack_delay_fix = -1;
        spurious_en   = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            vblank   = ($urandom_range(0, 9) < 7);
            abort    = ($urandom_range(0, 49) == 0);
            start    = ($urandom_range(0, 9) == 0);
            src_addr = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                                   : ($urandom & 32'hFFFF_FFFC);
            dst_addr = AW'($urandom);
            len      = (AW+1)'($urandom_range(0, 9));
        end
        @(posedge clk);
        #1;
        start  = 1'b0;
        abort  = 1'b0;
        vblank = 1'b1;
        wait_idle(200, "rand_drain_timeout");
        check(done_count > 0 && wr_addr_log.size() > 20, "rand_activity",
              64'(wr_addr_log.size()), 64'(21));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
